// File: rtl/i2s_pkg.sv
// i2s_pkg: shared channel type, frame geometry and channel-mode encodings for the I2S receiver.
package i2s_pkg;
    typedef enum logic {CH_LEFT, CH_RIGHT} i2s_ch_e;
    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS = 32;
    localparam int CH_MODE_LEFT = 0;
    localparam int CH_MODE_RIGHT = 1;
    localparam int CH_MODE_BOTH = 2;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk into SCK, walks the 64-bit frame and derives WS, slot and channel.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    output logic                         sck_o,
    output logic                         ws_o,
    output logic                         sck_rise_o,
    output logic                         sck_fall_o,
    output logic [$clog2(SLOT_BITS)-1:0] slot_o,
    output i2s_ch_e                      ch_o
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          tc;
    assign tc = div_cnt == DW'(CLK_DIV - 1);
    // Pulses are combinational so the receiver acts on the same edge SCK toggles, before bit_cnt moves.
    assign sck_rise_o = enable_i && tc && !sck_o;
    assign sck_fall_o = enable_i && tc && sck_o;
    assign ws_o = bit_cnt[BW-1];
    assign slot_o = bit_cnt[BW-2:0];
    assign ch_o = i2s_ch_e'(bit_cnt[BW-1]);
    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i) begin
            div_cnt <= '0;
            sck_o <= 1'b0;
            bit_cnt <= BW'(FRAME_BITS - 1);
        end else begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
            if (tc) sck_o <= !sck_o;
            if (sck_fall_o) bit_cnt <= bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S master receiver; synchronises SD, shifts in each slot and pushes selected samples to a FIFO.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int OUT_WIDTH    = 32,
    parameter int CHANNEL_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 sd_i,
    output logic                 sck_o,
    output logic                 ws_o,
    output logic                 wr_en_o,
    output logic [OUT_WIDTH-1:0] write_data_o,
    output logic                 ch_o,
    input  logic                 fifo_full_i,
    output logic                 overflow_o
);
    localparam logic [4:0] SW = 5'(SAMPLE_WIDTH);
    logic                    sd_meta, sd_s, sck_fall, cap, done, sel;
    logic [4:0]              slot;
    i2s_ch_e                 ch;
    logic [SAMPLE_WIDTH-1:0] shreg, sample;
    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_i),
        .sck_o     (sck_o),
        .ws_o      (ws_o),
        .sck_rise_o(),
        .sck_fall_o(sck_fall),
        .slot_o    (slot),
        .ch_o      (ch)
    );
    assign sample = SAMPLE_WIDTH'({shreg, sd_s});
    assign cap = sck_fall && slot != 5'd0 && slot <= SW;
    assign done = sck_fall && slot == SW;
    assign sel = CHANNEL_MODE == CH_MODE_BOTH || ((ch == CH_RIGHT) == (CHANNEL_MODE == CH_MODE_RIGHT));
    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i) begin
            sd_meta <= 1'b0;
            sd_s <= 1'b0;
            shreg <= '0;
            wr_en_o <= 1'b0;
            write_data_o <= '0;
            ch_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            sd_meta <= sd_i;
            sd_s <= sd_meta;
            wr_en_o <= 1'b0;
            if (cap) shreg <= sample;
            if (done && sel) begin
                if (fifo_full_i) begin
                    overflow_o <= 1'b1;
                end else begin
                    wr_en_o <= 1'b1;
                    write_data_o <= OUT_WIDTH'($signed(sample));
                    ch_o <= ch;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven frames plus hand sequences for disable, reset and overflow corners.
module tb_i2s_rx;
    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        full;
        logic [31:0] el;
        logic [31:0] er;
        logic        ovf;
    } frame_t;
    typedef struct {
        logic [31:0] d;
        logic        c;
        int          t;
    } push_t;

    logic clk = 1'b0, rst_n = 1'b0, enable_i = 1'b0, sd_i = 1'b0, fifo_full_i = 1'b0;
    logic sck_l, ws_l, wr_l, ch_l, ovf_l, sck_b, ws_b, wr_b, ch_b, ovf_b;
    logic [31:0] d_l, d_b;
    int total = 0, bad = 0, cyc = 0;
    push_t ql[$], qb[$];

    i2s_rx #(.CLK_DIV(4), .SAMPLE_WIDTH(24), .OUT_WIDTH(32), .CHANNEL_MODE(0)) u_l (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .sd_i(sd_i), .sck_o(sck_l), .ws_o(ws_l),
        .wr_en_o(wr_l), .write_data_o(d_l), .ch_o(ch_l), .fifo_full_i(fifo_full_i), .overflow_o(ovf_l));
    i2s_rx #(.CLK_DIV(4), .SAMPLE_WIDTH(24), .OUT_WIDTH(32), .CHANNEL_MODE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .sd_i(sd_i), .sck_o(sck_b), .ws_o(ws_b),
        .wr_en_o(wr_b), .write_data_o(d_b), .ch_o(ch_b), .fifo_full_i(fifo_full_i), .overflow_o(ovf_b));

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;
    initial forever begin
        @(negedge clk);
        if (wr_l) ql.push_back('{d_l, ch_l, cyc});
        if (wr_b) qb.push_back('{d_b, ch_b, cyc});
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endfunction

    function automatic logic sd_bit(frame_t v, int b);
        int s = b % 32;
        logic [23:0] w = (b >= 32) ? v.r : v.l;
        return (s >= 1 && s <= 24) ? w[24-s] : 1'b1;
    endfunction

    task automatic drive_bits(input frame_t v, input int n, output int perr, output int werr);
        int t0 = 0;
        perr = 0;
        werr = 0;
        for (int b = 0; b < n; b++) begin
            @(negedge sck_b);
            sd_i = sd_bit(v, b);
            if (b > 0 && cyc - t0 != 8) perr++;
            t0 = cyc;
            @(negedge clk);
            if (ws_b !== (b >= 32) || ws_l !== (b >= 32)) werr++;
        end
    endtask

    task automatic run_frame(input frame_t v);
        int perr, werr;
        ql.delete();
        qb.delete();
        fifo_full_i = v.full;
        drive_bits(v, 64, perr, werr);
        fifo_full_i = 1'b0;
        chk("sck_period_errs", perr, 0);
        chk("ws_errs", werr, 0);
        chk("l_push_count", ql.size(), v.full ? 0 : 1);
        chk("b_push_count", qb.size(), v.full ? 0 : 2);
        if (ql.size() == 1) begin
            chk("l_data", ql[0].d, v.el);
            chk("l_ch", ql[0].c, 0);
        end
        if (qb.size() == 2) begin
            chk("b_data_left", qb[0].d, v.el);
            chk("b_ch_left", qb[0].c, 0);
            chk("b_data_right", qb[1].d, v.er);
            chk("b_ch_right", qb[1].c, 1);
            chk("b_push_gap", qb[1].t - qb[0].t, 256);
            chk("b_data_hold", d_b, v.er);
        end
        chk("l_overflow", ovf_l, v.ovf);
        chk("b_overflow", ovf_b, v.ovf);
    endtask

    task automatic chk_idle(string n);
        chk({n, "_sck"}, sck_b, 0);
        chk({n, "_ws"}, ws_b, 1);
        chk({n, "_wr_en"}, wr_b, 0);
        chk({n, "_data"}, d_b, 0);
        chk({n, "_ch"}, ch_b, 0);
        chk({n, "_ovf_b"}, ovf_b, 0);
        chk({n, "_ovf_l"}, ovf_l, 0);
        chk({n, "_wr_en_l"}, wr_l, 0);
    endtask

    frame_t tbl[5];
    frame_t fa, fb, fp;
    int perr, werr;

    initial begin
        tbl[0] = '{24'h800001, 24'h123456, 1'b0, 32'hFF800001, 32'h00123456, 1'b0};
        tbl[1] = '{24'h123456, 24'h7FFFFF, 1'b0, 32'h00123456, 32'h007FFFFF, 1'b0};
        tbl[2] = '{24'h000000, 24'hFFFFFF, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[3] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1, 32'hFFA5A5A5, 32'h005A5A5A, 1'b1};
        tbl[4] = '{24'h7FFFFF, 24'h800000, 1'b0, 32'h007FFFFF, 32'hFF800000, 1'b1};
        fa = '{24'h654321, 24'h00ABCD, 1'b0, 32'h00654321, 32'h0000ABCD, 1'b0};
        fb = '{24'hFEDCBA, 24'h000001, 1'b0, 32'hFFFEDCBA, 32'h00000001, 1'b0};
        fp = '{24'h111111, 24'h222222, 1'b0, 32'h0, 32'h0, 1'b0};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("idle");

        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("sck_before_first_rise", sck_b, 0);
        @(negedge clk);
        chk("sck_first_rise", sck_b, 1);
        chk("ws_before_first_fall", ws_b, 1);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        ql.delete();
        qb.delete();
        drive_bits(fp, 13, perr, werr);
        enable_i = 1'b0;
        @(negedge clk);
        chk_idle("disable");
        repeat (20) @(negedge clk);
        chk("pushes_after_disable", ql.size() + qb.size(), 0);
        enable_i = 1'b1;
        run_frame(fa);

        ql.delete();
        qb.delete();
        fifo_full_i = 1'b1;
        drive_bits(fp, 41, perr, werr);
        fifo_full_i = 1'b0;
        chk("pre_reset_ovf_b", ovf_b, 1);
        chk("pre_reset_ovf_l", ovf_l, 1);
        chk("pre_reset_pushes", ql.size() + qb.size(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midframe_reset");
        rst_n = 1'b1;
        run_frame(fb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
